dff_shift_bank: RTL and testbench
=================================

# dff_shift_bank

Parametrised successor to the single D flip-flop with complementary outputs. It is a WIDTH-bit, DEPTH-stage register bank with per-stage valid tracking and four operating modes: hold, shift, parallel load and clear. It drives true and complementary outputs from the last stage. It sits wherever the design needs a configurable delay line or staging register and replaces chains of discrete flops.

## Interface
Parameters:
- WIDTH, 8, data width per stage (≥1)
- DEPTH, 4, number of stages (≥1)
- RESET_VAL, '0, WIDTH-bit value loaded into every stage on reset and on clear

Ports:
- clk  in  1  rising-edge clock; single clock domain
- reset  in  1  synchronous, active-high reset
- mode  in  2  operation select, of type dff_pkg::mode_t: HOLD=0, SHIFT=1, LOAD=2, CLEAR=3
- d  in  WIDTH  serial input to stage 0
- d_valid  in  1  valid tag shifted in with d
- load_data  in  DEPTH*WIDTH  parallel load image; slice [i*WIDTH +: WIDTH] goes to stage i
- q  out  WIDTH  stage DEPTH-1 data
- qb  out  WIDTH  bitwise complement of q
- q_valid  out  1  valid tag of stage DEPTH-1
- fill_count  out  $clog2(DEPTH+1)  number of stages with a set valid tag
- full  out  1  fill_count == DEPTH
- empty  out  1  fill_count == 0

## Operation
- State per stage i: data[i] (WIDTH bits) and vld[i] (1 bit).
- The behaviour at each rising clk edge has this priority: reset > mode.
- reset=1: every data[i] <= RESET_VAL, every vld[i] <= 0, fill_count <= 0.
- HOLD: no state change.
- SHIFT: data[0] <= d, vld[0] <= d_valid; data[i] <= data[i-1] and vld[i] <= vld[i-1] for i ≥ 1. Contents of the last stage are discarded. No backpressure.
- LOAD: data[i] <= load_data slice i and vld[i] <= 1 for all i. d and d_valid are ignored.
- CLEAR: identical to reset, except it is mode-driven.
- fill_count is a register. It is updated on the same edge as vld to equal popcount(next vld). It must never lag vld by a cycle.
- The following outputs are combinational from registered state only (no input-to-output paths):
  - q = data[DEPTH-1]
  - qb = ~q
  - q_valid = vld[DEPTH-1]
  - full and empty, decoded from fill_count
- Invariant, checked by assertion at every posedge: qb == ~q, including during and after reset. With WIDTH=1 this is the q != qb property.
- Invariant: fill_count == $countones(vld).
- DEPTH=1: the block behaves as one WIDTH-bit flop with enable (SHIFT), preset (LOAD) and clear.

## Timing
- Reset values:
  - q = RESET_VAL, qb = ~RESET_VAL
  - q_valid = 0, fill_count = 0
  - empty = 1, full = 0
- Shift latency: a value sampled with SHIFT at edge n appears on q after the DEPTH-th consecutive SHIFT edge, counting edge n as the first. HOLD cycles stretch the latency one-for-one.
- LOAD result is visible on q, q_valid and fill_count (=DEPTH) one cycle after the LOAD edge.
- A SHIFT with d_valid=1 while full and q_valid=1 is legal. fill_count stays at DEPTH.
- A SHIFT with d_valid=0 while full drops fill_count by the number of valid tags lost, net of the bubble entering. Example: shifting out a valid stage while a bubble enters decrements fill_count by 1.
- Reset asserted mid-shift wins on that edge. The in-flight data is lost and there is no partial update.
- The mode value X is illegal, and an assertion flags it when reset=0.

## Structure
- Package dff_pkg:
  - typedef enum logic [1:0] mode_t (HOLD, SHIFT, LOAD, CLEAR)
  - localparam for the mode-width constant
- Sub-module dff_stage:
  - one WIDTH-bit stage plus valid bit, with the sync reset/clear/load/shift mux
  - instantiated DEPTH times in a generate loop
  - parameters WIDTH and RESET_VAL
- The top level holds the generate loop, the fill_count register with its popcount of next-valid, the output decode and the assertions.

## Test plan
WIDTH=8, DEPTH=4, RESET_VAL=8'h00 unless stated.
- Reset for 2 cycles with mode=SHIFT and d=8'hFF → q=8'h00, qb=8'hFF, q_valid=0, empty=1, fill_count=0.
- SHIFT four valid values 8'h11, 8'h22, 8'h33, 8'h44 → after edge 4: q=8'h11, qb=8'hEE, full=1. The 5th shift (8'h55) gives q=8'h22.
- LOAD load_data=32'hA3B2C1D0 from empty → next cycle: q=8'hA3, fill_count=4. A following CLEAR gives q=8'h00, fill_count=0.
- SHIFT 8'h11 valid, HOLD for 3 cycles, then SHIFT 3 bubbles → q=8'h11 and q_valid=1 only after the 4th SHIFT edge; fill_count stays 1 throughout.
- From full, assert reset together with mode=LOAD → all stages become RESET_VAL and fill_count=0, confirming reset priority.
- Run RESET_VAL=8'h5A with DEPTH=1 → after reset q=8'h5A, qb=8'hA5. SHIFT 8'h0F gives q=8'h0F one edge later. The qb==~q assertion must never fire.

Source files
------------

// File: rtl/dff_shift_bank_pkg.sv
// Shared types for the shift bank: the operating mode encoding.
package dff_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    HOLD  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2,
    CLEAR = 2'd3
  } mode_t;

endpackage

// File: rtl/dff_shift_bank_if.sv
// Control/data bundle of the shift bank. The master drives mode and data. The slave returns the tail stage and the occupancy flags.
interface dff_shift_bank_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  import dff_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  mode_t                    mode;
  logic [WIDTH-1:0]         d;
  logic                     d_valid;
  logic [DEPTH*WIDTH-1:0]   load_data;
  logic [WIDTH-1:0]         q;
  logic [WIDTH-1:0]         qb;
  logic                     q_valid;
  logic [CW-1:0]            fill_count;
  logic                     full;
  logic                     empty;

  modport master (
    output mode, d, d_valid, load_data,
    input  q, qb, q_valid, fill_count, full, empty
  );

  modport slave (
    input  mode, d, d_valid, load_data,
    output q, qb, q_valid, fill_count, full, empty
  );

endinterface

// File: rtl/dff_shift_bank_stage.sv
// One stage of the bank. It holds a data word and its valid tag.
// Reset and CLEAR restore RESET_VAL. LOAD presets the stage. SHIFT takes the upstream word.
module dff_stage
  import dff_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  mode_t            i_mode,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_d_valid,
  input  logic [WIDTH-1:0] i_load,
  output logic [WIDTH-1:0] o_data,
  output logic             o_vld
);

  logic [WIDTH-1:0] r_data;
  logic             r_vld;

  // Reset has priority over the mode. HOLD and any unknown mode leave the stage untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= RESET_VAL;
      r_vld  <= 1'b0;
    end else begin
      case (i_mode)
        SHIFT: begin
          r_data <= i_d;
          r_vld  <= i_d_valid;
        end
        LOAD: begin
          r_data <= i_load;
          r_vld  <= 1'b1;
        end
        CLEAR: begin
          r_data <= RESET_VAL;
          r_vld  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_data = r_data;
  assign o_vld  = r_vld;

endmodule

// File: rtl/dff_shift_bank.sv
// WIDTH x DEPTH register bank with per-stage valid tags. It drives true and complementary outputs from the last stage.
// It also keeps a registered count of valid stages.
module dff_shift_bank
  import dff_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  dff_shift_bank_if.slave  bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] w_data;
  logic [DEPTH-1:0][WIDTH-1:0] w_din;
  logic [DEPTH-1:0]            w_vld;
  logic [DEPTH-1:0]            w_vin;
  logic [DEPTH-1:0]            w_vld_nxt;
  logic [CW-1:0]               w_fill_nxt;
  logic [CW-1:0]               r_fill_count;

  // Stage 0 takes the serial input. Every later stage takes its predecessor.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign w_din[i] = bus.d;
      assign w_vin[i] = bus.d_valid;
    end else begin : g_link
      assign w_din[i] = w_data[i-1];
      assign w_vin[i] = w_vld[i-1];
    end

    dff_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .i_mode    (bus.mode),
      .i_d       (w_din[i]),
      .i_d_valid (w_vin[i]),
      .i_load    (bus.load_data[i*WIDTH +: WIDTH]),
      .o_data    (w_data[i]),
      .o_vld     (w_vld[i])
    );
  end

  // Predict the valid vector the stages will hold after this edge.
  // The count is registered from this prediction, so it never lags the stages.
  always_comb begin
    w_vld_nxt = w_vld;
    case (bus.mode)
      SHIFT:   w_vld_nxt = w_vin;
      LOAD:    w_vld_nxt = '1;
      CLEAR:   w_vld_nxt = '0;
      default: w_vld_nxt = w_vld;
    endcase
    w_fill_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      w_fill_nxt = w_fill_nxt + CW'(w_vld_nxt[i]);
  end

  // Occupancy register, reset alongside the stages.
  always_ff @(posedge clk) begin
    if (reset) r_fill_count <= '0;
    else       r_fill_count <= w_fill_nxt;
  end

  assign bus.q          = w_data[DEPTH-1];
  assign bus.qb         = ~w_data[DEPTH-1];
  assign bus.q_valid    = w_vld[DEPTH-1];
  assign bus.fill_count = r_fill_count;
  assign bus.full       = (r_fill_count == CW'(DEPTH));
  assign bus.empty      = (r_fill_count == '0);

  a_q_qb: assert property (@(posedge clk) bus.qb == ~bus.q);

  a_fill_pop: assert property (@(posedge clk) disable iff (reset)
    r_fill_count == CW'($countones(w_vld)));

  a_mode_known: assert property (@(posedge clk) disable iff (reset)
    !$isunknown(bus.mode));

endmodule

// File: tb/tb_dff_shift_bank.sv
// Directed test of dff_shift_bank. A 4-deep bank and a 1-deep bank with RESET_VAL=5A share one clock and one reset.
module tb_dff_shift_bank;
  import dff_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dff_shift_bank_if #(.WIDTH(8), .DEPTH(4)) u_if4 ();
  dff_shift_bank_if #(.WIDTH(8), .DEPTH(1)) u_if1 ();

  dff_shift_bank #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if4.slave)
  );

  dff_shift_bank #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h5A)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if1.slave)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv4(input mode_t m, input logic [7:0] d, input logic v);
    u_if4.mode = m; u_if4.d = d; u_if4.d_valid = v;
  endtask

  initial begin
    reset = 1'b1;
    drv4(SHIFT, 8'hFF, 1'b1);
    u_if4.load_data = 32'h0;
    u_if1.mode = HOLD; u_if1.d = 8'h00; u_if1.d_valid = 1'b0; u_if1.load_data = 8'h00;

    // reset with SHIFT and d=FF applied
    step(2);
    chk("rst_q",     32'(u_if4.q),          32'h00);
    chk("rst_qb",    32'(u_if4.qb),         32'hFF);
    chk("rst_qv",    32'(u_if4.q_valid),    32'd0);
    chk("rst_empty", 32'(u_if4.empty),      32'd1);
    chk("rst_full",  32'(u_if4.full),       32'd0);
    chk("rst_fill",  32'(u_if4.fill_count), 32'd0);
    chk("d1_rst_q",  32'(u_if1.q),          32'h5A);
    chk("d1_rst_qb", 32'(u_if1.qb),         32'hA5);

    // fill with four valid words
    reset = 1'b0;
    drv4(SHIFT, 8'h11, 1'b1); step(1);
    chk("sh1_q",    32'(u_if4.q),          32'h00);
    chk("sh1_fill", 32'(u_if4.fill_count), 32'd1);
    drv4(SHIFT, 8'h22, 1'b1); step(1);
    drv4(SHIFT, 8'h33, 1'b1); step(1);
    chk("sh3_qv",   32'(u_if4.q_valid),    32'd0);
    chk("sh3_fill", 32'(u_if4.fill_count), 32'd3);
    drv4(SHIFT, 8'h44, 1'b1); step(1);
    chk("sh4_q",    32'(u_if4.q),          32'h11);
    chk("sh4_qb",   32'(u_if4.qb),         32'hEE);
    chk("sh4_full", 32'(u_if4.full),       32'd1);
    chk("sh4_qv",   32'(u_if4.q_valid),    32'd1);
    drv4(SHIFT, 8'h55, 1'b1); step(1);
    chk("sh5_q",    32'(u_if4.q),          32'h22);
    chk("sh5_fill", 32'(u_if4.fill_count), 32'd4);

    // clear, then parallel load, then clear
    drv4(CLEAR, 8'h00, 1'b0); step(1);
    chk("clr_empty", 32'(u_if4.empty),      32'd1);
    u_if4.load_data = 32'hA3B2C1D0;
    drv4(LOAD, 8'hEE, 1'b0); step(1);
    chk("ld_q",     32'(u_if4.q),          32'hA3);
    chk("ld_fill",  32'(u_if4.fill_count), 32'd4);
    chk("ld_full",  32'(u_if4.full),       32'd1);
    drv4(CLEAR, 8'h00, 1'b0); step(1);
    chk("clr2_q",    32'(u_if4.q),          32'h00);
    chk("clr2_fill", 32'(u_if4.fill_count), 32'd0);

    // one valid word, HOLD stretches latency, then bubbles push it out
    drv4(SHIFT, 8'h11, 1'b1); step(1);
    chk("one_fill", 32'(u_if4.fill_count), 32'd1);
    drv4(HOLD, 8'h99, 1'b1); step(3);
    chk("hold_fill", 32'(u_if4.fill_count), 32'd1);
    chk("hold_qv",   32'(u_if4.q_valid),    32'd0);
    drv4(SHIFT, 8'h00, 1'b0); step(2);
    chk("bub2_qv",   32'(u_if4.q_valid),    32'd0);
    chk("bub2_fill", 32'(u_if4.fill_count), 32'd1);
    step(1);
    chk("bub3_q",    32'(u_if4.q),          32'h11);
    chk("bub3_qv",   32'(u_if4.q_valid),    32'd1);
    chk("bub3_fill", 32'(u_if4.fill_count), 32'd1);
    step(1);
    chk("out_q",     32'(u_if4.q),          32'h00);
    chk("out_empty", 32'(u_if4.empty),      32'd1);

    // while full, a bubble entering drops the count by one
    drv4(LOAD, 8'h00, 1'b0); step(1);
    drv4(SHIFT, 8'h00, 1'b0); step(1);
    chk("fb_q",    32'(u_if4.q),          32'hB2);
    chk("fb_fill", 32'(u_if4.fill_count), 32'd3);
    chk("fb_full", 32'(u_if4.full),       32'd0);

    // while full, a valid word entering keeps the count at DEPTH
    drv4(LOAD, 8'h00, 1'b0); step(1);
    drv4(SHIFT, 8'h77, 1'b1); step(1);
    chk("fv_fill", 32'(u_if4.fill_count), 32'd4);
    chk("fv_q",    32'(u_if4.q),          32'hB2);

    // single-stage bank: enable, preset, clear
    drv4(HOLD, 8'h00, 1'b0);
    u_if1.mode = SHIFT; u_if1.d = 8'h0F; u_if1.d_valid = 1'b1; step(1);
    chk("d1_sh_q",    32'(u_if1.q),          32'h0F);
    chk("d1_sh_qb",   32'(u_if1.qb),         32'hF0);
    chk("d1_sh_full", 32'(u_if1.full),       32'd1);
    u_if1.mode = LOAD; u_if1.load_data = 8'h33; step(1);
    chk("d1_ld_q",    32'(u_if1.q),          32'h33);
    u_if1.mode = CLEAR; step(1);
    chk("d1_clr_q",   32'(u_if1.q),          32'h5A);
    chk("d1_clr_fill",32'(u_if1.fill_count), 32'd0);
    u_if1.mode = HOLD;
    chk("d4_held_q",  32'(u_if4.q),          32'hB2);

    // reset beats LOAD while full
    drv4(LOAD, 8'h00, 1'b0); reset = 1'b1; step(1);
    chk("rp_q",     32'(u_if4.q),          32'h00);
    chk("rp_qv",    32'(u_if4.q_valid),    32'd0);
    chk("rp_fill",  32'(u_if4.fill_count), 32'd0);
    chk("rp_empty", 32'(u_if4.empty),      32'd1);
    reset = 1'b0;
    drv4(HOLD, 8'h00, 1'b0); step(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
